fw_cmd_sequencer: RTL and testbench

Per-firmware command sequencer behind the SW-to-FW op-code decoder; one instance per device-ID slot. Consumes a one-cycle register-write strobe plus the decoded op-code strobes and 24-bit body. Owns static/array configuration storage, the execute state machine that gates the pixel datapath, data-array capture, and the 32-bit read-data/read-status words returned to SW.

---
 rtl/fw_cmd_seq_pkg.sv | 26 ++
 rtl/fw_exec_fsm.sv | 79 +++++++
 rtl/fw_cmd_sequencer.sv | 169 ++++++++++++++++
 tb/tb_fw_cmd_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fw_cmd_seq_pkg.sv
// Shared constants for the per-device firmware command sequencer:
// exec FSM encodings, status/body field positions and the read-error word.
package fw_cmd_seq_pkg;

    typedef enum logic [1:0] {
        EXEC_IDLE = 2'd0,
        EXEC_RUN  = 2'd1,
        EXEC_DONE = 2'd2
    } exec_state_e;

    localparam int ST_BUSY      = 0;
    localparam int ST_DONE      = 1;
    localparam int ST_ERR       = 2;
    localparam int ST_OVF       = 3;
    localparam int ST_TGT       = 4;
    localparam int ST_STATE_LSB = 8;
    localparam int ST_PTR_LSB   = 16;
    localparam int ST_CNT_LSB   = 24;

    localparam int BODY_IDX_LSB = 16;
    localparam int BODY_SEL     = 16;
    localparam int BODY_CLR_PTR = 17;

    localparam logic [31:0] READ_ERR = 32'hDEAD_0000;

endpackage

// File: rtl/fw_exec_fsm.sv
// Execute state machine: run-cycle counter, datapath gate, capture pointer
// into the selected data array, and the sticky done/overflow flags.
module fw_exec_fsm
    import fw_cmd_seq_pkg::*;
#(
    parameter int DATA_ARRAY_DEPTH = 16,
    parameter int PTR_W            = $clog2(DATA_ARRAY_DEPTH + 1),
    parameter int DA_AW            = $clog2(DATA_ARRAY_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             exec_go,
    input  logic [15:0]      exec_n,
    input  logic             exec_sel,
    input  logic             exec_clr_ptr,
    input  logic             status_clear,
    input  logic             dp_data_valid,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic             target,
    output logic [1:0]       state,
    output logic [PTR_W-1:0] wr_ptr,
    output logic             cap_we,
    output logic [DA_AW-1:0] cap_addr
);

    localparam logic [1:0] ST_IDLE = EXEC_IDLE;
    localparam logic [1:0] ST_RUN  = EXEC_RUN;
    localparam logic [1:0] ST_DONE = EXEC_DONE;

    logic [15:0] run_cnt;
    logic        ptr_full;

    assign busy     = (state == ST_RUN);
    assign ptr_full = (32'(wr_ptr) >= DATA_ARRAY_DEPTH);
    assign cap_we   = busy & dp_data_valid & ~ptr_full;
    assign cap_addr = wr_ptr[DA_AW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            run_cnt  <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
            target   <= 1'b0;
            wr_ptr   <= '0;
        end else begin
            // DONE is not busy, so a new execute may be taken straight from it
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (exec_go) begin
                        run_cnt <= exec_n;
                        state   <= (exec_n == 16'd0) ? ST_DONE : ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (run_cnt == 16'd1) state <= ST_DONE;
                    else                  run_cnt <= run_cnt - 16'd1;
                end
                default: state <= ST_IDLE;
            endcase

            if (exec_go) target <= exec_sel;

            if (status_clear)           done <= 1'b0;
            else if (state == ST_DONE)  done <= 1'b1;

            if (status_clear)                     overflow <= 1'b0;
            else if (busy & dp_data_valid & ptr_full) overflow <= 1'b1;

            if (status_clear || (exec_go && exec_clr_ptr)) wr_ptr <= '0;
            else if (cap_we)                               wr_ptr <= wr_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/fw_cmd_sequencer.sv
// Per-device command sequencer: decodes accepted op strobes, owns config and
// data storage, the read-data register and the SW-visible status word.
module fw_cmd_sequencer
    import fw_cmd_seq_pkg::*;
#(
    parameter int CFG_STATIC_WORDS = 4,
    parameter int CFG_ARRAY_DEPTH  = 16,
    parameter int DATA_ARRAY_DEPTH = 16
) (
    input  logic                          fw_axi_clk,
    input  logic                          fw_rst,
    input  logic                          sw_write_strobe,
    input  logic                          fw_dev_enable,
    input  logic                          fw_op_code_w_reset,
    input  logic                          fw_op_code_w_cfg_static_0,
    input  logic                          fw_op_code_w_cfg_static_1,
    input  logic                          fw_op_code_r_cfg_static_0,
    input  logic                          fw_op_code_r_cfg_static_1,
    input  logic                          fw_op_code_w_cfg_array_0,
    input  logic                          fw_op_code_w_cfg_array_1,
    input  logic                          fw_op_code_r_cfg_array_0,
    input  logic                          fw_op_code_r_cfg_array_1,
    input  logic                          fw_op_code_r_data_array_0,
    input  logic                          fw_op_code_r_data_array_1,
    input  logic                          fw_op_code_w_status_clear,
    input  logic                          fw_op_code_w_execute,
    input  logic [23:0]                   sw_write24_0,
    input  logic                          dp_data_valid,
    input  logic [15:0]                   dp_data,
    output logic                          dp_enable,
    output logic [16*CFG_STATIC_WORDS-1:0] cfg_static_0,
    output logic [16*CFG_STATIC_WORDS-1:0] cfg_static_1,
    output logic [31:0]                   fw_read_data32,
    output logic [31:0]                   fw_read_status32
);

    localparam int SW_AW = $clog2(CFG_STATIC_WORDS);
    localparam int AA_AW = $clog2(CFG_ARRAY_DEPTH);
    localparam int DA_AW = $clog2(DATA_ARRAY_DEPTH);
    localparam int PTR_W = $clog2(DATA_ARRAY_DEPTH + 1);

    logic [1:0][CFG_STATIC_WORDS-1:0][15:0] cfg_st;
    logic [1:0][CFG_ARRAY_DEPTH-1:0][15:0]  cfg_ar;
    logic [1:0][DATA_ARRAY_DEPTH-1:0][15:0] data_ar;
    logic                                   err;
    logic [7:0]                             cmd_cnt;

    logic [12:0] ops;
    logic        cmd_acc, multi;
    logic [12:0] op_v;

    assign ops = {fw_op_code_w_execute, fw_op_code_w_status_clear,
                  fw_op_code_r_data_array_1, fw_op_code_r_data_array_0,
                  fw_op_code_r_cfg_array_1, fw_op_code_r_cfg_array_0,
                  fw_op_code_w_cfg_array_1, fw_op_code_w_cfg_array_0,
                  fw_op_code_r_cfg_static_1, fw_op_code_r_cfg_static_0,
                  fw_op_code_w_cfg_static_1, fw_op_code_w_cfg_static_0,
                  fw_op_code_w_reset};

    // More than one strobe is rejected outright; op_v carries only a clean single op
    assign cmd_acc = sw_write_strobe & fw_dev_enable;
    assign multi   = |(ops & (ops - 13'd1));
    assign op_v    = (cmd_acc && !multi) ? ops : '0;

    logic [3:0]  st_idx;
    logic [7:0]  ar_idx;
    logic        st_ok, ar_ok, da_ok;
    logic        is_w_st, is_w_ar, is_r_st, is_r_ar, is_r_da, do_exec, do_clr;
    logic        busy, done, overflow, target, cap_we, exec_go, err_set, rst_all;
    logic [1:0]  state;
    logic [PTR_W-1:0] wr_ptr;
    logic [DA_AW-1:0] cap_addr;
    logic [31:0] rd_next;

    assign st_idx  = sw_write24_0[BODY_IDX_LSB +: 4];
    assign ar_idx  = sw_write24_0[BODY_IDX_LSB +: 8];
    assign st_ok   = 32'(st_idx) < CFG_STATIC_WORDS;
    assign ar_ok   = 32'(ar_idx) < CFG_ARRAY_DEPTH;
    assign da_ok   = 32'(ar_idx) < DATA_ARRAY_DEPTH;

    assign is_w_st = op_v[1] | op_v[2];
    assign is_r_st = op_v[3] | op_v[4];
    assign is_w_ar = op_v[5] | op_v[6];
    assign is_r_ar = op_v[7] | op_v[8];
    assign is_r_da = op_v[9] | op_v[10];
    assign do_clr  = op_v[11];
    assign do_exec = op_v[12];
    assign rst_all = fw_rst | op_v[0];
    assign exec_go = do_exec & ~busy;

    assign err_set = (cmd_acc & multi)
                   | (is_w_st & (busy | ~st_ok))
                   | (is_w_ar & (busy | ~ar_ok))
                   | (do_exec & busy)
                   | (is_r_st & ~st_ok)
                   | (is_r_ar & ~ar_ok)
                   | (is_r_da & ~da_ok);

    fw_exec_fsm #(.DATA_ARRAY_DEPTH(DATA_ARRAY_DEPTH)) u_exec (
        .clk          (fw_axi_clk),
        .rst          (rst_all),
        .exec_go      (exec_go),
        .exec_n       (sw_write24_0[15:0]),
        .exec_sel     (sw_write24_0[BODY_SEL]),
        .exec_clr_ptr (sw_write24_0[BODY_CLR_PTR]),
        .status_clear (do_clr),
        .dp_data_valid(dp_data_valid),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow),
        .target       (target),
        .state        (state),
        .wr_ptr       (wr_ptr),
        .cap_we       (cap_we),
        .cap_addr     (cap_addr)
    );

    always_comb begin
        rd_next = READ_ERR;
        if (op_v[3] && st_ok)  rd_next = {16'h0, cfg_st[0][st_idx[SW_AW-1:0]]};
        if (op_v[4] && st_ok)  rd_next = {16'h0, cfg_st[1][st_idx[SW_AW-1:0]]};
        if (op_v[7] && ar_ok)  rd_next = {16'h0, cfg_ar[0][ar_idx[AA_AW-1:0]]};
        if (op_v[8] && ar_ok)  rd_next = {16'h0, cfg_ar[1][ar_idx[AA_AW-1:0]]};
        if (op_v[9] && da_ok)  rd_next = {16'h0, data_ar[0][ar_idx[DA_AW-1:0]]};
        if (op_v[10] && da_ok) rd_next = {16'h0, data_ar[1][ar_idx[DA_AW-1:0]]};
    end

    always_ff @(posedge fw_axi_clk) begin
        if (rst_all) begin
            cfg_st         <= '0;
            cfg_ar         <= '0;
            data_ar        <= '0;
            err            <= 1'b0;
            cmd_cnt        <= '0;
            fw_read_data32 <= '0;
        end else begin
            if (op_v[1] && !busy && st_ok) cfg_st[0][st_idx[SW_AW-1:0]] <= sw_write24_0[15:0];
            if (op_v[2] && !busy && st_ok) cfg_st[1][st_idx[SW_AW-1:0]] <= sw_write24_0[15:0];
            if (op_v[5] && !busy && ar_ok) cfg_ar[0][ar_idx[AA_AW-1:0]] <= sw_write24_0[15:0];
            if (op_v[6] && !busy && ar_ok) cfg_ar[1][ar_idx[AA_AW-1:0]] <= sw_write24_0[15:0];
            if (cap_we) data_ar[target][cap_addr] <= dp_data;

            if (is_r_st | is_r_ar | is_r_da) fw_read_data32 <= rd_next;

            if (do_clr)       err <= 1'b0;
            else if (err_set) err <= 1'b1;

            if (do_clr)       cmd_cnt <= '0;
            else if (cmd_acc) cmd_cnt <= cmd_cnt + 8'd1;
        end
    end

    assign dp_enable    = busy;
    assign cfg_static_0 = cfg_st[0];
    assign cfg_static_1 = cfg_st[1];

    always_comb begin
        fw_read_status32                       = '0;
        fw_read_status32[ST_BUSY]              = busy;
        fw_read_status32[ST_DONE]              = done;
        fw_read_status32[ST_ERR]               = err;
        fw_read_status32[ST_OVF]               = overflow;
        fw_read_status32[ST_TGT]               = target;
        fw_read_status32[ST_STATE_LSB +: 2]    = state;
        fw_read_status32[ST_PTR_LSB +: 8]      = 8'(wr_ptr);
        fw_read_status32[ST_CNT_LSB +: 8]      = cmd_cnt;
    end

endmodule

// File: tb/tb_fw_cmd_sequencer.sv
// Directed bench for fw_cmd_sequencer: inputs change on the falling edge,
// outputs are sampled on the falling edge after the command's rising edge.
module tb_fw_cmd_sequencer;

    localparam int OP_W_RESET = 0,  OP_W_ST0 = 1,  OP_W_ST1 = 2,  OP_R_ST0 = 3;
    localparam int OP_R_ST1   = 4,  OP_W_AR0 = 5,  OP_W_AR1 = 6,  OP_R_AR0 = 7;
    localparam int OP_R_AR1   = 8,  OP_R_DA0 = 9,  OP_R_DA1 = 10, OP_CLR   = 11;
    localparam int OP_EXEC    = 12;

    logic        fw_axi_clk = 1'b0;
    logic        fw_rst = 1'b1;
    logic        sw_write_strobe = 1'b0;
    logic        fw_dev_enable = 1'b1;
    logic [12:0] ops = '0;
    logic [23:0] sw_write24_0 = '0;
    logic        dp_data_valid = 1'b0;
    logic [15:0] dp_data = '0;
    logic        dp_enable;
    logic [63:0] cfg_static_0, cfg_static_1;
    logic [31:0] fw_read_data32, fw_read_status32;

    int checks = 0;
    int errors = 0;
    int en_cnt;

    always #5 fw_axi_clk = ~fw_axi_clk;

    fw_cmd_sequencer dut (
        .fw_axi_clk               (fw_axi_clk),
        .fw_rst                   (fw_rst),
        .sw_write_strobe          (sw_write_strobe),
        .fw_dev_enable            (fw_dev_enable),
        .fw_op_code_w_reset       (ops[OP_W_RESET]),
        .fw_op_code_w_cfg_static_0(ops[OP_W_ST0]),
        .fw_op_code_w_cfg_static_1(ops[OP_W_ST1]),
        .fw_op_code_r_cfg_static_0(ops[OP_R_ST0]),
        .fw_op_code_r_cfg_static_1(ops[OP_R_ST1]),
        .fw_op_code_w_cfg_array_0 (ops[OP_W_AR0]),
        .fw_op_code_w_cfg_array_1 (ops[OP_W_AR1]),
        .fw_op_code_r_cfg_array_0 (ops[OP_R_AR0]),
        .fw_op_code_r_cfg_array_1 (ops[OP_R_AR1]),
        .fw_op_code_r_data_array_0(ops[OP_R_DA0]),
        .fw_op_code_r_data_array_1(ops[OP_R_DA1]),
        .fw_op_code_w_status_clear(ops[OP_CLR]),
        .fw_op_code_w_execute     (ops[OP_EXEC]),
        .sw_write24_0             (sw_write24_0),
        .dp_data_valid            (dp_data_valid),
        .dp_data                  (dp_data),
        .dp_enable                (dp_enable),
        .cfg_static_0             (cfg_static_0),
        .cfg_static_1             (cfg_static_1),
        .fw_read_data32           (fw_read_data32),
        .fw_read_status32         (fw_read_status32)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s did not match", tag);
        end
    endtask

    // One-cycle command: driven on a falling edge, returns one cycle later.
    task automatic send(input logic [12:0] o, input logic [23:0] b, input logic en);
        @(negedge fw_axi_clk);
        sw_write_strobe = 1'b1;
        fw_dev_enable   = en;
        ops             = o;
        sw_write24_0    = b;
        @(negedge fw_axi_clk);
        sw_write_strobe = 1'b0;
        fw_dev_enable   = 1'b1;
        ops             = '0;
    endtask

    task automatic cmd(input int op, input logic [23:0] b);
        logic [12:0] o;
        o = '0;
        o[op] = 1'b1;
        send(o, b, 1'b1);
    endtask

    initial begin
        logic [12:0] two;
        repeat (2) @(negedge fw_axi_clk);
        chk("rst_status", 64'(fw_read_status32), 64'h0);
        chk("rst_rdata",  64'(fw_read_data32),   64'h0);
        chk("rst_cfg0",   cfg_static_0,          64'h0);
        chk("rst_dpen",   64'(dp_enable),        64'h0);
        fw_rst = 1'b0;

        // static write/read
        cmd(OP_W_ST0, 24'h02_A5A5);
        chk("st_write_vis", cfg_static_0, 64'h0000_A5A5_0000_0000);
        cmd(OP_R_ST0, 24'h02_0000);
        chk("st_read",      64'(fw_read_data32),   64'h0000_A5A5);
        chk("st_count2",    64'(fw_read_status32), 64'h0200_0000);

        // out-of-range index
        cmd(OP_W_ST1, 24'h04_1234);
        chk("st_oor_err",   64'(fw_read_status32), 64'h0300_0004);
        chk("st_oor_nowr",  cfg_static_1,          64'h0);
        cmd(OP_R_ST0, 24'h05_0000);
        chk("st_oor_rd",    64'(fw_read_data32),   64'hDEAD_0000);
        cmd(OP_CLR, 24'h0);
        chk("clr_status",   64'(fw_read_status32), 64'h0);

        // cfg array last entry and first out-of-range address
        cmd(OP_W_AR1, 24'h0F_BEEF);
        cmd(OP_R_AR1, 24'h0F_0000);
        chk("ar_read15",    64'(fw_read_data32),   64'h0000_BEEF);
        cmd(OP_R_AR1, 24'h10_0000);
        chk("ar_read16",    64'(fw_read_data32),   64'hDEAD_0000);
        chk("ar_read16_err",64'(fw_read_status32), 64'h0300_0004);
        cmd(OP_CLR, 24'h0);

        // execute N=5 into array 0, three valids including the last RUN cycle
        cmd(OP_EXEC, 24'h02_0005);
        en_cnt = 0;
        for (int c = 1; c <= 7; c++) begin
            if (c > 1) @(negedge fw_axi_clk);
            en_cnt += int'(dp_enable);
            dp_data_valid = (c == 1 || c == 3 || c == 5);
            dp_data       = 16'((c + 1) / 2);
            if (c == 6) chk("ex5_done_state", 64'(fw_read_status32), 64'h0103_0200);
            if (c == 7) chk("ex5_done",       64'(fw_read_status32), 64'h0103_0002);
        end
        dp_data_valid = 1'b0;
        chk("ex5_en_cycles", 64'(en_cnt), 64'd5);
        cmd(OP_R_DA0, 24'h02_0000);
        chk("ex5_entry2",   64'(fw_read_data32), 64'h0000_0003);
        cmd(OP_R_DA0, 24'h00_0000);
        chk("ex5_entry0",   64'(fw_read_data32), 64'h0000_0001);

        // execute N=20 into array 1 with a valid every cycle -> overflow
        cmd(OP_CLR, 24'h0);
        cmd(OP_EXEC, 24'h03_0014);
        en_cnt = 0;
        for (int c = 1; c <= 22; c++) begin
            if (c > 1) @(negedge fw_axi_clk);
            en_cnt += int'(dp_enable);
            dp_data_valid = (c <= 20);
            dp_data       = 16'(16'h0100 + c - 1);
            if (c == 22) chk("ovf_status", 64'(fw_read_status32), 64'h0110_001A);
        end
        dp_data_valid = 1'b0;
        chk("ovf_en_cycles", 64'(en_cnt), 64'd20);
        cmd(OP_R_DA1, 24'h0F_0000);
        chk("ovf_entry15",  64'(fw_read_data32), 64'h0000_010F);
        cmd(OP_R_DA1, 24'h00_0000);
        chk("ovf_entry0",   64'(fw_read_data32), 64'h0000_0100);
        cmd(OP_R_DA0, 24'h02_0000);
        chk("ovf_other_arr",64'(fw_read_data32), 64'h0000_0003);

        // cfg write while busy
        cmd(OP_CLR, 24'h0);
        chk("clr_keeps_tgt",64'(fw_read_status32), 64'h0000_0010);
        cmd(OP_EXEC, 24'h00_0004);
        cmd(OP_W_ST0, 24'h00_1111);
        chk("busy_wr_err",  64'(fw_read_status32), 64'h0200_0105);
        chk("busy_wr_nowr", cfg_static_0,          64'h0000_A5A5_0000_0000);
        repeat (3) @(negedge fw_axi_clk);
        chk("busy_wr_done", 64'(fw_read_status32), 64'h0200_0006);
        cmd(OP_CLR, 24'h0);
        chk("clr_all",      64'(fw_read_status32), 64'h0);

        // two strobes, disabled device, NOOP
        two = '0;
        two[OP_W_ST0] = 1'b1;
        two[OP_R_ST0] = 1'b1;
        send(two, 24'h01_7777, 1'b1);
        chk("multi_err",    64'(fw_read_status32), 64'h0100_0004);
        chk("multi_nocfg",  cfg_static_0,          64'h0000_A5A5_0000_0000);
        chk("multi_nord",   64'(fw_read_data32),   64'h0000_0003);
        two = '0;
        two[OP_W_ST0] = 1'b1;
        send(two, 24'h01_7777, 1'b0);
        chk("dis_status",   64'(fw_read_status32), 64'h0100_0004);
        chk("dis_nocfg",    cfg_static_0,          64'h0000_A5A5_0000_0000);
        send(13'h0, 24'h0, 1'b1);
        chk("noop_count",   64'(fw_read_status32), 64'h0200_0004);

        // N=0 goes straight to DONE
        cmd(OP_CLR, 24'h0);
        cmd(OP_EXEC, 24'h00_0000);
        chk("n0_done_state",64'(fw_read_status32), 64'h0100_0200);
        @(negedge fw_axi_clk);
        chk("n0_done",      64'(fw_read_status32), 64'h0100_0002);

        // soft reset during RUN cycle 3 of N=10
        cmd(OP_W_ST1, 24'h03_1234);
        chk("st1_w3",       cfg_static_1, 64'h1234_0000_0000_0000);
        cmd(OP_EXEC, 24'h00_000A);
        @(negedge fw_axi_clk);
        cmd(OP_W_RESET, 24'h0);
        chk("srst_dpen",    64'(dp_enable),        64'h0);
        chk("srst_status",  64'(fw_read_status32), 64'h0);
        chk("srst_cfg0",    cfg_static_0,          64'h0);
        chk("srst_cfg1",    cfg_static_1,          64'h0);
        chk("srst_rdata",   64'(fw_read_data32),   64'h0);
        @(negedge fw_axi_clk);
        chk("srst_nodone",  64'(fw_read_status32), 64'h0);

        // execute accepted in the DONE cycle, then hard reset mid-RUN
        cmd(OP_EXEC, 24'h00_0001);
        cmd(OP_EXEC, 24'h00_0002);
        chk("exec_in_done", 64'(fw_read_status32), 64'h0200_0103);
        @(negedge fw_axi_clk);
        fw_rst = 1'b1;
        @(negedge fw_axi_clk);
        fw_rst = 1'b0;
        chk("hrst_dpen",    64'(dp_enable),        64'h0);
        chk("hrst_status",  64'(fw_read_status32), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
